// File: rtl/lidar_pwm_proximity.sv
// Three-channel LIDAR PWM front end: pulse-width measurement, N-sample near/far confirmation, liveness timeout.
// Define LIDAR_PROX_HYST_EN to enable the neutral band [NEAR_CM, FAR_CM) in which both streaks hold.
module lidar_pwm_proximity #(
    parameter int TICK_DIV      = 500,
    parameter int CNT_W         = 10,
    parameter int NEAR_CM       = 100,
    parameter int FAR_CM        = 120,
    parameter int CONFIRM       = 2,
    parameter int TIMEOUT_TICKS = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] pwm_in,
    output logic [2:0] near,
    output logic [2:0] alive,
    output logic [2:0] meas_stb
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] WMAX       = '1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]    SIL_MAX    = SW'(TIMEOUT_TICKS);
    localparam logic [SW-1:0]    SIL_LAST   = SW'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]       CONF       = 4'(CONFIRM);

`ifdef LIDAR_PROX_HYST_EN
    localparam int FAR_TH = FAR_CM;
    if (FAR_CM < NEAR_CM) begin : g_bad_far
        $error("FAR_CM must be >= NEAR_CM when the hysteresis band is enabled");
    end
`else
    // Without the band the far threshold collapses onto NEAR_CM and FAR_CM has no effect.
    localparam int FAR_TH = NEAR_CM + 0 * FAR_CM;
`endif

    typedef enum logic [1:0] {WAIT_LOW, WAIT_HIGH, MEASURE} state_t;

    logic [2:0]       sync1_q, sync2_q, prev_q;
    logic [1:0]       prime_q;
    logic [PW-1:0]    presc_q;
    state_t           state_q   [3];
    logic [CNT_W-1:0] width_q   [3];
    logic [SW-1:0]    silence_q [3];
    logic [3:0]       nstreak_q [3];
    logic [3:0]       fstreak_q [3];
    logic [2:0]       near_q, alive_q, stb_q;

    logic             tick;
    logic [2:0]       rise, fall, done, tmo, near_smp, far_smp;
    logic [3:0]       nstreak_d [3];
    logic [3:0]       fstreak_d [3];

    always_comb begin
        tick = ena && (presc_q == PRESC_LAST);
        for (int i = 0; i < 3; i++) begin
            rise[i]      = sync2_q[i] & ~prev_q[i];
            fall[i]      = ~sync2_q[i] & prev_q[i];
            done[i]      = (state_q[i] == MEASURE) && fall[i];
            // A completion in the same cycle clears silence, so it beats the timeout.
            tmo[i]       = tick && !done[i] && (silence_q[i] == SIL_LAST);
            near_smp[i]  = (width_q[i] != WMAX) && (32'(width_q[i]) < 32'(NEAR_CM));
            far_smp[i]   = (width_q[i] == WMAX) || (32'(width_q[i]) >= 32'(FAR_TH));
            nstreak_d[i] = (nstreak_q[i] == CONF) ? CONF : nstreak_q[i] + 4'd1;
            fstreak_d[i] = (fstreak_q[i] == CONF) ? CONF : fstreak_q[i] + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            prime_q <= '0;
            presc_q <= '0;
            near_q  <= '0;
            alive_q <= '0;
            stb_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i]   <= WAIT_LOW;
                width_q[i]   <= '0;
                silence_q[i] <= '0;
                nstreak_q[i] <= '0;
                fstreak_q[i] <= '0;
            end
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            // The synchronizer holds reset zeros for two cycles; WAIT_LOW must not trust them.
            prime_q <= {prime_q[0], 1'b1};
            if (!ena) begin
                stb_q <= '0;
            end else begin
                presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
                for (int i = 0; i < 3; i++) begin
                    stb_q[i] <= done[i];
                    if (done[i]) begin
                        silence_q[i] <= '0;
                    end else if (tick && silence_q[i] != SIL_MAX) begin
                        silence_q[i] <= silence_q[i] + 1'b1;
                    end
                    if (tmo[i]) begin
                        alive_q[i]   <= 1'b0;
                        near_q[i]    <= 1'b0;
                        nstreak_q[i] <= '0;
                        fstreak_q[i] <= '0;
                        state_q[i]   <= WAIT_LOW;
                    end else begin
                        case (state_q[i])
                            WAIT_LOW: begin
                                if (prime_q[1] && !sync2_q[i]) state_q[i] <= WAIT_HIGH;
                            end
                            WAIT_HIGH: begin
                                if (rise[i]) begin
                                    width_q[i] <= '0;
                                    state_q[i] <= MEASURE;
                                end
                            end
                            MEASURE: begin
                                if (fall[i]) begin
                                    alive_q[i] <= 1'b1;
                                    state_q[i] <= WAIT_HIGH;
                                    if (near_smp[i]) begin
                                        nstreak_q[i] <= nstreak_d[i];
                                        fstreak_q[i] <= '0;
                                        if (nstreak_d[i] == CONF) near_q[i] <= 1'b1;
                                    end else if (far_smp[i]) begin
                                        fstreak_q[i] <= fstreak_d[i];
                                        nstreak_q[i] <= '0;
                                        if (fstreak_d[i] == CONF) near_q[i] <= 1'b0;
                                    end
                                end else if (tick && width_q[i] != WMAX) begin
                                    width_q[i] <= width_q[i] + 1'b1;
                                end
                            end
                            default: state_q[i] <= WAIT_LOW;
                        endcase
                    end
                end
            end
        end
    end

    assign near     = near_q;
    assign alive    = alive_q;
    assign meas_stb = stb_q;

endmodule

// File: tb/tb_lidar_pwm_proximity.sv
// Bench for lidar_pwm_proximity: random and directed pulses, expected strobe results queued per channel.
`timescale 1ns/1ps
module tb_lidar_pwm_proximity;
  localparam int TICK_DIV      = 2;
  localparam int CNT_W         = 10;
  localparam int NEAR_CM       = 100;
  localparam int FAR_CM        = 120;
  localparam int CONFIRM       = 2;
  localparam int TIMEOUT_TICKS = 300;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  logic pwm0 = 1'b0, pwm1 = 1'b0, pwm2 = 1'b0;
  logic [2:0] pwm_in, near, alive, meas_stb;
  assign pwm_in = {pwm2, pwm1, pwm0};

  lidar_pwm_proximity #(
    .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .NEAR_CM(NEAR_CM), .FAR_CM(FAR_CM),
    .CONFIRM(CONFIRM), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_in),
    .near(near), .alive(alive), .meas_stb(meas_stb)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  // scoreboard: one queue per channel, entries are {near, alive} expected at the strobe
  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];
  logic [1:0] exp_q2[$];

  // reference model: history of non-neutral samples since the last timeout
  logic [7:0] hist [3];
  int         hist_n [3];
  logic       near_m [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 1 = near, 0 = far, 2 = neutral
  function automatic int classify(input int width_clk);
    int ticks;
    ticks = width_clk / TICK_DIV;
    if (ticks < NEAR_CM) return 1;
`ifdef LIDAR_PROX_HYST_EN
    if (ticks < FAR_CM) return 2;
`endif
    return 0;
  endfunction

  task automatic model_clear(input int ch);
    hist[ch] = '0;
    hist_n[ch] = 0;
    near_m[ch] = 1'b0;
  endtask

  task automatic model_sample(input int ch, input int width_clk);
    int c;
    logic [7:0] m;
    logic [1:0] e;
    c = classify(width_clk);
    m = 8'((1 << CONFIRM) - 1);
    if (c != 2) begin
      hist[ch] = {hist[ch][6:0], (c == 1)};
      if (hist_n[ch] < 8) hist_n[ch]++;
      if (hist_n[ch] >= CONFIRM) begin
        if ((hist[ch] & m) == m) near_m[ch] = 1'b1;
        else if ((hist[ch] & m) == 8'd0) near_m[ch] = 1'b0;
      end
    end
    e = {near_m[ch], 1'b1};
    case (ch)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // monitor
  task automatic mon_pop(input int ch);
    logic [1:0] e;
    int sz;
    case (ch)
      0: sz = exp_q0.size();
      1: sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    if (sz == 0) begin
      check($sformatf("ch%0d_unexpected_strobe", ch), 32'd1, 32'd0);
    end else begin
      case (ch)
        0: e = exp_q0.pop_front();
        1: e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      check($sformatf("ch%0d_near_at_strobe", ch), 32'(near[ch]), 32'(e[1]));
      check($sformatf("ch%0d_alive_at_strobe", ch), 32'(alive[ch]), 32'(e[0]));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (meas_stb[ch] === 1'b1) mon_pop(ch);
        else if (meas_stb[ch] !== 1'b0) check($sformatf("ch%0d_strobe_known", ch), 32'(meas_stb[ch]), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic set_pwm(input int ch, input logic v);
    case (ch)
      0: pwm0 = v;
      1: pwm1 = v;
      default: pwm2 = v;
    endcase
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    model_sample(ch, hi);
    set_pwm(ch, 1'b1);
    repeat (hi) @(negedge clk);
    set_pwm(ch, 1'b0);
    repeat (lo) @(negedge clk);
  endtask

  // idle long enough for every channel to time out, then confirm the timeout state
  task automatic settle();
    pwm0 = 1'b0; pwm1 = 1'b0; pwm2 = 1'b0;
    repeat (700) @(negedge clk);
    for (int ch = 0; ch < 3; ch++) model_clear(ch);
    check("settle_near", 32'(near), 32'd0);
    check("settle_alive", 32'(alive), 32'd0);
  endtask

  // ch2 pulse of 240 clk with ena low for 50 clk inside it
  task automatic pulse_gap(input logic [2:0] exp_near, input logic [2:0] exp_alive, input bit poke_ch1);
    model_sample(2, 190);
    pwm2 = 1'b1;
    repeat (80) @(negedge clk);
    ena = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (poke_ch1 && k == 25) pwm1 = 1'b1;
      @(negedge clk);
      check("gap_meas_stb", 32'(meas_stb), 32'd0);
      check("gap_near", 32'(near), 32'(exp_near));
      check("gap_alive", 32'(alive), 32'(exp_alive));
    end
    ena = 1'b1;
    for (int k = 0; k < 110; k++) begin
      if (poke_ch1 && k == 30) pwm1 = 1'b0;
      @(negedge clk);
    end
    pwm2 = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic rand_chan(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      int cls;
      int hi;
      int lo;
      cls = $urandom_range(0, 2);
      lo = $urandom_range(10, 60);
      case (cls)
        0: hi = $urandom_range(20, 190);
        1: hi = $urandom_range(210, 230);
        default: hi = $urandom_range(250, 500);
      endcase
      pulse(ch, hi, lo);
    end
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int ch = 0; ch < 3; ch++) model_clear(ch);

    // reset with all lines high
    pwm0 = 1'b1; pwm1 = 1'b1; pwm2 = 1'b1;
    ena = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_near", 32'(near), 32'd0);
    check("reset_alive", 32'(alive), 32'd0);
    check("reset_meas_stb", 32'(meas_stb), 32'd0);
    mon_en = 1'b1;
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("held_high_alive", 32'(alive), 32'd0);
    pwm0 = 1'b0; pwm1 = 1'b0; pwm2 = 1'b0;
    repeat (20) @(negedge clk);
    fork
      pulse(0, 100, 20);
      pulse(1, 100, 20);
      pulse(2, 100, 20);
    join
    check("first_pulse_alive", 32'(alive), 32'd7);
    settle();

    // near confirm and release on ch0
    pulse(0, 100, 40);
    pulse(0, 100, 40);
    check("confirm_near0", 32'(near[0]), 32'd1);
    pulse(0, 400, 40);
    pulse(0, 400, 40);
    check("release_near0", 32'(near[0]), 32'd0);
    pulse(0, 100, 40);
    pulse(0, 100, 40);
    pulse(0, 400, 40);
    pulse(0, 100, 40);
    check("single_far_near0", 32'(near[0]), 32'd1);
    settle();

    // timeout on ch1 with the line stuck high
    pulse(1, 100, 40);
    pulse(1, 100, 40);
    check("pre_timeout_near1", 32'(near[1]), 32'd1);
    pwm1 = 1'b1;
    repeat (700) @(negedge clk);
    model_clear(1);
    check("timeout_alive1", 32'(alive[1]), 32'd0);
    check("timeout_near1", 32'(near[1]), 32'd0);
    pwm1 = 1'b0;
    repeat (40) @(negedge clk);
    pulse(1, 100, 40);
    check("rearm_alive1", 32'(alive[1]), 32'd1);
    settle();

    // ena freeze mid-pulse on ch2; a ch1 rise inside the gap is lost
    pulse_gap(3'b000, 3'b000, 1'b1);
    pulse_gap(3'b000, 3'b100, 1'b0);
    check("ena_near2", 32'(near[2]), 32'(near_m[2]));
    check("ena_lost_edge_alive1", 32'(alive[1]), 32'd0);
    settle();

    // neutral-band widths on ch0
    pulse(0, 100, 40);
    pulse(0, 100, 40);
    for (int k = 0; k < 10; k++) pulse(0, 220, 40);
    check("band_near0", 32'(near[0]), 32'(near_m[0]));
    check("band_alive0", 32'(alive[0]), 32'd1);
    pulse(0, 260, 40);
    pulse(0, 260, 40);
    check("band_release_near0", 32'(near[0]), 32'd0);
    settle();

    // random traffic on all channels at once
    fork
      rand_chan(0, 12);
      rand_chan(1, 12);
      rand_chan(2, 12);
    join
    repeat (20) @(negedge clk);
    check("ch0_pending", 32'(exp_q0.size()), 32'd0);
    check("ch1_pending", 32'(exp_q1.size()), 32'd0);
    check("ch2_pending", 32'(exp_q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
